// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between control unit and MUL/DIV engine
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, op, A, B,
    input  busy, done, div_by_zero, result_hi, result_lo
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, div_by_zero, result_hi, result_lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed Booth multiplier / non-restoring divider
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic         clk,
  input  logic         clr,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_r;
  logic             b_sign;
  logic             b_zero;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] mcand;
  // acc/lo/qm1 hold {HI, LO, q-1} for MUL and {remainder, quotient} for DIV
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] lo;
  logic             qm1;

  logic [WIDTH:0]   lhs;
  logic [WIDTH:0]   rhs;
  logic [WIDTH:0]   sum;
  logic             sub;
  logic [WIDTH:0]   nacc;
  logic [WIDTH-1:0] nlo;
  logic             nqm1;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  assign abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

  always_comb begin
    lhs = '0;
    rhs = '0;
    sub = 1'b0;
    if (op_r) begin
      lhs = {acc[WIDTH-1:0], lo[WIDTH-1]};
      rhs = {1'b0, mcand};
      sub = ~acc[WIDTH];
    end else begin
      lhs = {acc[WIDTH-1], acc[WIDTH-1:0]};
      rhs = {mcand[WIDTH-1], mcand};
      case ({lo[0], qm1})
        2'b01:   sub = 1'b0;
        2'b10:   sub = 1'b1;
        default: rhs = '0;
      endcase
    end
    sum = sub ? lhs - rhs : lhs + rhs;
    if (op_r) begin
      nacc = sum;
      nlo  = {lo[WIDTH-2:0], ~sum[WIDTH]};
      nqm1 = qm1;
    end else begin
      // arithmetic right shift of the full-width Booth sum into HI:LO
      nacc = {sum[WIDTH], sum[WIDTH:1]};
      nlo  = {sum[0], lo[WIDTH-1:1]};
      nqm1 = lo[0];
    end
  end

  always_comb begin
    rem_mag = acc[WIDTH] ? acc[WIDTH-1:0] + mcand : acc[WIDTH-1:0];
    fin_hi  = acc[WIDTH-1:0];
    fin_lo  = lo;
    if (op_r) begin
      if (b_zero) begin
        fin_hi = a_r;
        fin_lo = '1;
      end else begin
        fin_hi = a_r[WIDTH-1] ? -rem_mag : rem_mag;
        fin_lo = (a_r[WIDTH-1] ^ b_sign) ? -lo : lo;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state           <= IDLE;
      cnt             <= '0;
      op_r            <= 1'b0;
      b_sign          <= 1'b0;
      b_zero          <= 1'b0;
      a_r             <= '0;
      mcand           <= '0;
      acc             <= '0;
      lo              <= '0;
      qm1             <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.result_hi   <= '0;
      bus.result_lo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_r            <= bus.op;
            a_r             <= bus.A;
            b_sign          <= bus.B[WIDTH-1];
            b_zero          <= (bus.B == '0);
            cnt             <= '0;
            acc             <= '0;
            qm1             <= 1'b0;
            lo              <= bus.op ? abs_a : bus.B;
            mcand           <= bus.op ? abs_b : bus.A;
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b1;
            state           <= RUN;
          end
        end
        RUN: begin
          acc <= nacc;
          lo  <= nlo;
          qm1 <= nqm1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) state <= FIN;
        end
        FIN: begin
          bus.result_hi   <= fin_hi;
          bus.result_lo   <= fin_lo;
          bus.div_by_zero <= op_r & b_zero;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic busy_gap;

  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = ~o; bus.A = 32'h5A5A_1234; bus.B = 32'h0F0F_0F0F;
    busy_gap = !bus.busy;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.done && !bus.busy) busy_gap = 1'b1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; bus.start = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b expected 0", bus.div_by_zero); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h expected 0", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h expected 0", bus.result_lo); end
    @(negedge clk); clr = 1'b1;
  endtask

  task automatic test_mul_basic();
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d expected 33", lat); end
    checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL mul_busy_gap got %b expected 0", busy_gap); end
    checks++; if (bus.result_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_neg_hi got %h expected ffffffff", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_neg_lo got %h expected ffffffeb", bus.result_lo); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b expected 0", bus.done); end
    checks++; if (bus.result_lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_hold_lo got %h expected ffffffeb", bus.result_lo); end
  endtask

  task automatic test_mul_corner();
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    checks++; if (bus.result_hi !== 32'h4000_0000) begin errors++; $display("FAIL mul_min_hi got %h expected 40000000", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h0) begin errors++; $display("FAIL mul_min_lo got %h expected 0", bus.result_lo); end
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL mul_m1_hi got %h expected 0", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h1) begin errors++; $display("FAIL mul_m1_lo got %h expected 1", bus.result_lo); end
    do_op(1'b0, 32'd5, 32'd0);
    checks++; if ({bus.result_hi, bus.result_lo} !== 64'h0) begin errors++; $display("FAIL mul_zero got %h expected 0", {bus.result_hi, bus.result_lo}); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mul_zero_dbz got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_div();
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d expected 33", lat); end
    checks++; if (bus.result_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_q got %h expected fffffffd", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_r got %h expected ffffffff", bus.result_hi); end
    do_op(1'b1, 32'd100, 32'd7);
    checks++; if (bus.result_lo !== 32'd14) begin errors++; $display("FAIL div_100_q got %h expected e", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd2) begin errors++; $display("FAIL div_100_r got %h expected 2", bus.result_hi); end
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    checks++; if (bus.result_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7m2_q got %h expected fffffffd", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd1) begin errors++; $display("FAIL div_7m2_r got %h expected 1", bus.result_hi); end
  endtask

  task automatic test_div_zero();
    do_op(1'b1, 32'd100, 32'd0);
    checks++; if (lat !== 33) begin errors++; $display("FAIL dbz_latency got %0d expected 33", lat); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b expected 1", bus.div_by_zero); end
    checks++; if (bus.result_hi !== 32'h64) begin errors++; $display("FAIL dbz_hi got %h expected 64", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got %h expected ffffffff", bus.result_lo); end
    do_op(1'b0, 32'd2, 32'd3);
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b expected 0", bus.div_by_zero); end
    checks++; if (bus.result_lo !== 32'd6) begin errors++; $display("FAIL dbz_next_lo got %h expected 6", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd0) begin errors++; $display("FAIL dbz_next_hi got %h expected 0", bus.result_hi); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if (bus.result_lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q got %h expected 80000000", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL ovf_r got %h expected 0", bus.result_hi); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %b expected 0", bus.div_by_zero); end
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 32'hFFFF_FFFE; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b expected 1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got %b expected 0", bus.done); end
    n = 0;
    while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n + 1 !== 34) begin errors++; $display("FAIL b2b_spacing got %0d expected 34", n + 1); end
    checks++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFF6) begin errors++; $display("FAIL b2b_result got %h expected fffffffffffffff6", {bus.result_hi, bus.result_lo}); end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int at_edge;
    ndone = 0; at_edge = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 32'd123; bus.B = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin ndone++; at_edge = e; end
      if (e == 9) begin bus.start = 1'b1; bus.op = 1'b1; bus.A = 32'd50; bus.B = 32'd5; end
      if (e == 10) bus.start = 1'b0;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_ndone got %0d expected 1", ndone); end
    checks++; if (at_edge !== 33) begin errors++; $display("FAIL ignore_edge got %0d expected 33", at_edge); end
    checks++; if (bus.result_lo !== 32'd56088) begin errors++; $display("FAIL ignore_lo got %h expected db18", bus.result_lo); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.A = 32'd1000; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #3 clr = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b expected 0", bus.done); end
    checks++; if (bus.result_lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got %h expected 0", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got %h expected 0", bus.result_hi); end
    @(negedge clk); @(negedge clk); clr = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d expected 0", ndone); end
    do_op(1'b1, 32'd9, 32'd3);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rst_div_latency got %0d expected 33", lat); end
    checks++; if (bus.result_lo !== 32'd3) begin errors++; $display("FAIL rst_div_q got %h expected 3", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd0) begin errors++; $display("FAIL rst_div_r got %h expected 0", bus.result_hi); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_corner();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
